// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle MULT/DIV engine and its controller:
// operation encoding, FSM state encoding and the Booth recoding helper.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_e;

  // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out last step.
  function automatic booth_e booth_decode(input logic q0, input logic q_m1);
    booth_e res;
    case ({q0, q_m1})
      2'b01:   res = BOOTH_ADD;
      2'b10:   res = BOOTH_SUB;
      default: res = BOOTH_NOP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and the MULT/DIV engine (slave).
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_write;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hilo_write,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, hilo_write,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, sign-fixed) engine with
// architectural HI/LO. One WIDTH+1 adder/subtractor is shared by both algorithms.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  mult_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, m_q, m_d;
  logic             q1_q, q1_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, div0_q, div0_d;

  logic [WIDTH:0]   add_a_s, add_b_s, add_sum_s, booth_acc_s;
  logic             add_sub_s;
  logic             last_s, b_zero_s, div0_req_s;
  booth_e           booth_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign last_s     = (cnt_q == CW'(WIDTH - 1));
  assign b_zero_s   = (bus.b == {WIDTH{1'b0}});
  assign div0_req_s = (state_q == ST_IDLE) && bus.start && (bus.op == OP_DIV) && b_zero_s;
  assign booth_s    = booth_decode(mq_q[0], q1_q);

  // Shared adder: DIV trial-subtracts |b| from the shifted remainder, MUL adds/subtracts a.
  always_comb begin
    add_a_s   = {acc_q[WIDTH-1], acc_q};
    add_b_s   = {m_q[WIDTH-1], m_q};
    add_sub_s = 1'b0;
    if (state_q == ST_DIV) begin
      add_a_s   = {acc_q, mq_q[WIDTH-1]};
      add_b_s   = {1'b0, m_q};
      add_sub_s = 1'b1;
    end else begin
      add_sub_s = (booth_s == BOOTH_SUB);
    end
    add_sum_s   = add_a_s + (add_b_s ^ {(WIDTH+1){add_sub_s}}) + {{WIDTH{1'b0}}, add_sub_s};
    booth_acc_s = (booth_s == BOOTH_NOP) ? {acc_q[WIDTH-1], acc_q} : add_sum_s;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.start)                state_d = ST_IDLE;
        else if (bus.op == OP_MULT)    state_d = ST_MUL;
        else if (b_zero_s)             state_d = ST_DONE;
        else                           state_d = ST_DIV;
      end
      ST_MUL:  state_d = last_s ? ST_DONE : ST_MUL;
      ST_DIV:  state_d = last_s ? ST_FIX  : ST_DIV;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode, registered so busy/done/div0 leave the block glitch-free
  always_comb begin
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
    div0_d = div0_req_s;
  end

  // Datapath next-state: operand capture, iteration steps, sign fix-up, HI/LO commit
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    m_d       = m_q;
    q1_d      = q1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d     = {CW{1'b0}};
          acc_d     = {WIDTH{1'b0}};
          q1_d      = 1'b0;
          neg_quo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          neg_rem_d = bus.a[WIDTH-1];
          if (bus.op == OP_MULT) begin
            m_d  = bus.a;
            mq_d = bus.b;
          end else begin
            m_d  = abs_val(bus.b);
            mq_d = abs_val(bus.a);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MUL: begin
        acc_d = booth_acc_s[WIDTH:1];
        mq_d  = {booth_acc_s[0], mq_q[WIDTH-1:1]};
        q1_d  = mq_q[0];
        cnt_d = cnt_q + CW'(1);
        if (last_s) begin
          res_hi_d = booth_acc_s[WIDTH:1];
          res_lo_d = {booth_acc_s[0], mq_q[WIDTH-1:1]};
        end else begin
          res_hi_d = res_hi_q;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (!add_sum_s[WIDTH]) begin
          acc_d = add_sum_s[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end
      ST_FIX: begin
        res_lo_d = neg_quo_q ? (~mq_q + {{(WIDTH-1){1'b0}}, 1'b1}) : mq_q;
        res_hi_d = neg_rem_q ? (~acc_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q;
      end
      ST_DONE: cnt_d = cnt_q;
      default: cnt_d = {CW{1'b0}};
    endcase
  end

  // HI/LO copy whatever the result registers hold now, so a same-cycle start sees the old result
  always_comb begin
    if (bus.hilo_write) begin
      hi_d = res_hi_q;
      lo_d = res_lo_q;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      mq_q      <= {WIDTH{1'b0}};
      m_q       <= {WIDTH{1'b0}};
      q1_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_hi_q  <= {WIDTH{1'b0}};
      res_lo_q  <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
